// File: rtl/cross_bar_pkg.sv
// cross_bar_pkg: shared widths, command/arbiter enums and round-robin helper for the 4x4 crossbar.
package cross_bar_pkg;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int N_MASTERS = 4;
    localparam int N_SLAVES  = 4;

    typedef enum logic {CMD_READ = 1'b0, CMD_WRITE = 1'b1} cmd_e;
    typedef enum logic [1:0] {IDLE, LOCKED, WAIT_RESP} arb_state_e;
    typedef logic [1:0] midx_t;

    // First set bit of elig at or after ptr, searching circularly.
    function automatic midx_t rr_pick(input logic [N_MASTERS-1:0] elig, input midx_t ptr);
        midx_t idx;
        rr_pick = ptr;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            idx = ptr + midx_t'(i);
            if (elig[idx]) rr_pick = idx;
        end
    endfunction
endpackage

// File: rtl/cross_bar_if.sv
// cross_bar_if: request/acknowledge bus bundle shared by every crossbar port.
interface cross_bar_if;
    import cross_bar_pkg::*;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              cmd;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              resp;
    logic [DATA_W-1:0] rdata;
    modport slv (input req, addr, cmd, wdata, output ack, resp, rdata);
    modport mst (output req, addr, cmd, wdata, input ack, resp, rdata);
endinterface

// File: rtl/cross_bar_arbiter.sv
// cross_bar_arbiter: per-slave round-robin arbiter with IDLE / LOCKED / WAIT_RESP ownership.
// Define CROSS_BAR_SVA_EN to compile in grant and response checkers.
module cross_bar_arbiter
    import cross_bar_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] elig,
    input  logic [N_MASTERS-1:0] cmd,
    input  logic                 ack,
    input  logic                 resp,
    output logic                 grant_valid,
    output logic                 resp_valid,
    output midx_t                owner
);
    arb_state_e state, state_d;
    midx_t      owner_q, owner_d, ptr, ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner_q <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_d;
            owner_q <= owner_d;
            ptr     <= ptr_d;
        end
    end

    // Outputs are gated by rst_n so reset clears them without waiting for a clock.
    always_comb begin
        owner       = state == IDLE ? rr_pick(elig, ptr) : owner_q;
        grant_valid = rst_n && (state == IDLE ? |elig : state == LOCKED);
        resp_valid  = rst_n && state == WAIT_RESP;
        state_d     = state;
        owner_d     = owner_q;
        ptr_d       = ptr;
        if (state == WAIT_RESP) begin
            if (resp) state_d = IDLE;
        end else if (grant_valid) begin
            owner_d = owner;
            state_d = !ack ? LOCKED : (cmd[owner] == CMD_WRITE) ? IDLE : WAIT_RESP;
            if (ack) ptr_d = owner + 2'd1;
        end
    end

`ifdef CROSS_BAR_SVA_EN
    logic [N_MASTERS-1:0] grant;
    assign grant = grant_valid ? N_MASTERS'(1) << owner : '0;
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_grant_elig: assert property (@(posedge clk) disable iff (!rst_n)
        grant_valid && state == IDLE |-> elig[owner]);
    a_resp_wait: assert property (@(posedge clk) disable iff (!rst_n) resp |-> state == WAIT_RESP);
`endif
endmodule

// File: rtl/cross_bar_4x4.sv
// cross_bar_4x4: 4x4 req/ack bus crossbar; slave chosen by addr[31:30], per-slave round-robin.
// Define CROSS_BAR_SVA_EN to compile in protocol checkers.
module cross_bar_4x4
    import cross_bar_pkg::*;
(
    input logic      clk,
    input logic      rst_n,
    cross_bar_if.slv master_0_if,
    cross_bar_if.slv master_1_if,
    cross_bar_if.slv master_2_if,
    cross_bar_if.slv master_3_if,
    cross_bar_if.mst slave_0_if,
    cross_bar_if.mst slave_1_if,
    cross_bar_if.mst slave_2_if,
    cross_bar_if.mst slave_3_if
);
    logic [N_MASTERS-1:0] m_req, m_cmd, m_ack, m_resp, outst;
    logic [ADDR_W-1:0]    m_addr  [N_MASTERS];
    logic [DATA_W-1:0]    m_wdata [N_MASTERS];
    logic [DATA_W-1:0]    m_rdata [N_MASTERS];
    logic [N_SLAVES-1:0]  s_req, s_cmd, s_ack, s_resp, gnt_v, rsp_v;
    logic [ADDR_W-1:0]    s_addr  [N_SLAVES];
    logic [DATA_W-1:0]    s_wdata [N_SLAVES];
    logic [DATA_W-1:0]    s_rdata [N_SLAVES];
    logic [N_MASTERS-1:0] elig    [N_SLAVES];
    midx_t                owner   [N_SLAVES];

    assign m_req[0]   = master_0_if.req;
    assign m_addr[0]  = master_0_if.addr;
    assign m_cmd[0]   = master_0_if.cmd;
    assign m_wdata[0] = master_0_if.wdata;
    assign master_0_if.ack   = m_ack[0];
    assign master_0_if.resp  = m_resp[0];
    assign master_0_if.rdata = m_rdata[0];

    assign m_req[1]   = master_1_if.req;
    assign m_addr[1]  = master_1_if.addr;
    assign m_cmd[1]   = master_1_if.cmd;
    assign m_wdata[1] = master_1_if.wdata;
    assign master_1_if.ack   = m_ack[1];
    assign master_1_if.resp  = m_resp[1];
    assign master_1_if.rdata = m_rdata[1];

    assign m_req[2]   = master_2_if.req;
    assign m_addr[2]  = master_2_if.addr;
    assign m_cmd[2]   = master_2_if.cmd;
    assign m_wdata[2] = master_2_if.wdata;
    assign master_2_if.ack   = m_ack[2];
    assign master_2_if.resp  = m_resp[2];
    assign master_2_if.rdata = m_rdata[2];

    assign m_req[3]   = master_3_if.req;
    assign m_addr[3]  = master_3_if.addr;
    assign m_cmd[3]   = master_3_if.cmd;
    assign m_wdata[3] = master_3_if.wdata;
    assign master_3_if.ack   = m_ack[3];
    assign master_3_if.resp  = m_resp[3];
    assign master_3_if.rdata = m_rdata[3];

    assign slave_0_if.req   = s_req[0];
    assign slave_0_if.addr  = s_addr[0];
    assign slave_0_if.cmd   = s_cmd[0];
    assign slave_0_if.wdata = s_wdata[0];
    assign s_ack[0]   = slave_0_if.ack;
    assign s_resp[0]  = slave_0_if.resp;
    assign s_rdata[0] = slave_0_if.rdata;

    assign slave_1_if.req   = s_req[1];
    assign slave_1_if.addr  = s_addr[1];
    assign slave_1_if.cmd   = s_cmd[1];
    assign slave_1_if.wdata = s_wdata[1];
    assign s_ack[1]   = slave_1_if.ack;
    assign s_resp[1]  = slave_1_if.resp;
    assign s_rdata[1] = slave_1_if.rdata;

    assign slave_2_if.req   = s_req[2];
    assign slave_2_if.addr  = s_addr[2];
    assign slave_2_if.cmd   = s_cmd[2];
    assign slave_2_if.wdata = s_wdata[2];
    assign s_ack[2]   = slave_2_if.ack;
    assign s_resp[2]  = slave_2_if.resp;
    assign s_rdata[2] = slave_2_if.rdata;

    assign slave_3_if.req   = s_req[3];
    assign slave_3_if.addr  = s_addr[3];
    assign slave_3_if.cmd   = s_cmd[3];
    assign slave_3_if.wdata = s_wdata[3];
    assign s_ack[3]   = slave_3_if.ack;
    assign s_resp[3]  = slave_3_if.resp;
    assign s_rdata[3] = slave_3_if.rdata;

    // A master with a read in flight is withheld from every slave until its resp.
    always_comb begin
        for (int s = 0; s < N_SLAVES; s++)
            for (int m = 0; m < N_MASTERS; m++)
                elig[s][m] = m_req[m] && !outst[m] && m_addr[m][ADDR_W-1 -: 2] == 2'(s);
    end

    for (genvar s = 0; s < N_SLAVES; s++) begin : g_arb
        cross_bar_arbiter u_arb (
            .clk         (clk),
            .rst_n       (rst_n),
            .elig        (elig[s]),
            .cmd         (m_cmd),
            .ack         (s_ack[s]),
            .resp        (s_resp[s]),
            .grant_valid (gnt_v[s]),
            .resp_valid  (rsp_v[s]),
            .owner       (owner[s])
        );
    end

    always_comb begin
        m_ack  = '0;
        m_resp = '0;
        for (int m = 0; m < N_MASTERS; m++) m_rdata[m] = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            s_req[s]   = 1'b0;
            s_cmd[s]   = 1'b0;
            s_addr[s]  = '0;
            s_wdata[s] = '0;
            if (gnt_v[s]) begin
                s_req[s]        = m_req[owner[s]];
                s_cmd[s]        = m_cmd[owner[s]];
                s_addr[s]       = m_addr[owner[s]];
                s_wdata[s]      = m_wdata[owner[s]];
                m_ack[owner[s]] = m_ack[owner[s]] | s_ack[s];
            end
            if (rsp_v[s] && s_resp[s]) begin
                m_resp[owner[s]]  = 1'b1;
                m_rdata[owner[s]] = s_rdata[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) outst <= '0;
        else        outst <= (outst | (m_ack & ~m_cmd)) & ~m_resp;
    end

`ifdef CROSS_BAR_SVA_EN
    for (genvar m = 0; m < N_MASTERS; m++) begin : g_sva
        a_ack_req: assert property (@(posedge clk) disable iff (!rst_n) m_ack[m] |-> m_req[m]);
        a_stable: assert property (@(posedge clk) disable iff (!rst_n) m_req[m] && !m_ack[m]
            |=> $stable(m_addr[m]) && $stable(m_cmd[m]) && $stable(m_wdata[m]));
        w_outst: assert property (@(posedge clk) disable iff (!rst_n) outst[m] |-> !m_req[m])
            else $warning("master %0d requests while its read is outstanding", m);
    end
`endif
endmodule

// File: tb/tb_cross_bar_4x4.sv
// tb_cross_bar_4x4: directed checks of routing, round-robin order, locking, read return and reset.
module tb_cross_bar_4x4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m_req [4], m_cmd [4], m_ack [4], m_resp [4];
    logic [31:0] m_addr [4], m_wdata [4], m_rdata [4];
    logic        s_req [4], s_cmd [4], s_ack [4], s_resp [4];
    logic [31:0] s_addr [4], s_wdata [4], s_rdata [4];
    int tests = 0;
    int fails = 0;

    cross_bar_if m0 (), m1 (), m2 (), m3 ();
    cross_bar_if s0 (), s1 (), s2 (), s3 ();

    assign m0.req = m_req[0]; assign m0.addr = m_addr[0]; assign m0.cmd = m_cmd[0]; assign m0.wdata = m_wdata[0];
    assign m1.req = m_req[1]; assign m1.addr = m_addr[1]; assign m1.cmd = m_cmd[1]; assign m1.wdata = m_wdata[1];
    assign m2.req = m_req[2]; assign m2.addr = m_addr[2]; assign m2.cmd = m_cmd[2]; assign m2.wdata = m_wdata[2];
    assign m3.req = m_req[3]; assign m3.addr = m_addr[3]; assign m3.cmd = m_cmd[3]; assign m3.wdata = m_wdata[3];
    assign m_ack[0] = m0.ack; assign m_resp[0] = m0.resp; assign m_rdata[0] = m0.rdata;
    assign m_ack[1] = m1.ack; assign m_resp[1] = m1.resp; assign m_rdata[1] = m1.rdata;
    assign m_ack[2] = m2.ack; assign m_resp[2] = m2.resp; assign m_rdata[2] = m2.rdata;
    assign m_ack[3] = m3.ack; assign m_resp[3] = m3.resp; assign m_rdata[3] = m3.rdata;
    assign s_req[0] = s0.req; assign s_addr[0] = s0.addr; assign s_cmd[0] = s0.cmd; assign s_wdata[0] = s0.wdata;
    assign s_req[1] = s1.req; assign s_addr[1] = s1.addr; assign s_cmd[1] = s1.cmd; assign s_wdata[1] = s1.wdata;
    assign s_req[2] = s2.req; assign s_addr[2] = s2.addr; assign s_cmd[2] = s2.cmd; assign s_wdata[2] = s2.wdata;
    assign s_req[3] = s3.req; assign s_addr[3] = s3.addr; assign s_cmd[3] = s3.cmd; assign s_wdata[3] = s3.wdata;
    assign s0.ack = s_ack[0]; assign s0.resp = s_resp[0]; assign s0.rdata = s_rdata[0];
    assign s1.ack = s_ack[1]; assign s1.resp = s_resp[1]; assign s1.rdata = s_rdata[1];
    assign s2.ack = s_ack[2]; assign s2.resp = s_resp[2]; assign s2.rdata = s_rdata[2];
    assign s3.ack = s_ack[3]; assign s3.resp = s_resp[3]; assign s3.rdata = s_rdata[3];

    cross_bar_4x4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .master_0_if (m0),
        .master_1_if (m1),
        .master_2_if (m2),
        .master_3_if (m3),
        .slave_0_if  (s0),
        .slave_1_if  (s1),
        .slave_2_if  (s2),
        .slave_3_if  (s3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mset(input int i, input logic r, input logic c, input logic [31:0] a, input logic [31:0] d);
        m_req[i]   = r;
        m_cmd[i]   = c;
        m_addr[i]  = a;
        m_wdata[i] = d;
    endtask

    function automatic logic [3:0] ackv();
        return {m_ack[3], m_ack[2], m_ack[1], m_ack[0]};
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            mset(i, 0, 0, 0, 0);
            s_ack[i]   = 0;
            s_resp[i]  = 0;
            s_rdata[i] = 0;
        end
        // In reset: a live request and slave ack must not reach the outputs.
        mset(0, 1, 1, 32'h4000_0010, 32'hDEAD_BEEF);
        s_ack[1] = 1;
        #3;
        chk("rst_s1_req", s_req[1], 0);
        chk("rst_s1_addr", s_addr[1], 0);
        chk("rst_m0_ack", m_ack[0], 0);
        chk("rst_m0_rdata", m_rdata[0], 0);
        mset(0, 0, 0, 0, 0);
        s_ack[1] = 0;
        @(posedge clk);
        #4 rst_n = 1;
        tick;

        // Single write M0 -> S1.
        mset(0, 1, 1, 32'h4000_0010, 32'hDEAD_BEEF);
        #1;
        chk("wr_s1_req", s_req[1], 1);
        chk("wr_s1_addr", s_addr[1], 32'h4000_0010);
        chk("wr_s1_cmd", s_cmd[1], 1);
        chk("wr_s1_wdata", s_wdata[1], 32'hDEAD_BEEF);
        chk("wr_other_req", {s_req[3], s_req[2], s_req[0]}, 0);
        chk("wr_m0_ack_pre", m_ack[0], 0);
        s_ack[1] = 1;
        #1;
        chk("wr_m0_ack", m_ack[0], 1);
        tick;
        mset(0, 0, 0, 0, 0);
        s_ack[1] = 0;

        // Single read M2 -> S3, response three cycles after ack; M1 blocked meanwhile.
        mset(2, 1, 0, 32'hC000_0004, 0);
        #1;
        chk("rd_s3_req", s_req[3], 1);
        chk("rd_s3_addr", s_addr[3], 32'hC000_0004);
        chk("rd_s3_cmd", s_cmd[3], 0);
        s_ack[3] = 1;
        #1;
        chk("rd_m2_ack", m_ack[2], 1);
        tick;
        mset(2, 0, 0, 0, 0);
        s_ack[3] = 0;
        mset(1, 1, 1, 32'hC000_0008, 32'h5555_0001);
        #1;
        chk("rd_block1", s_req[3], 0);
        chk("rd_m1_ack_block", m_ack[1], 0);
        tick;
        #1;
        chk("rd_block2", s_req[3], 0);
        tick;
        s_resp[3]  = 1;
        s_rdata[3] = 32'h1234_5678;
        #1;
        chk("rd_m2_resp", m_resp[2], 1);
        chk("rd_m2_rdata", m_rdata[2], 32'h1234_5678);
        chk("rd_m1_resp", m_resp[1], 0);
        chk("rd_m1_rdata", m_rdata[1], 0);
        chk("rd_grant_wait", s_req[3], 0);
        tick;
        s_resp[3]  = 0;
        s_rdata[3] = 0;
        #1;
        chk("rd_m2_resp_pulse", m_resp[2], 0);
        chk("rd_next_req", s_req[3], 1);
        chk("rd_next_addr", s_addr[3], 32'hC000_0008);
        s_ack[3] = 1;
        #1;
        chk("rd_m1_ack", m_ack[1], 1);
        tick;
        mset(1, 0, 0, 0, 0);
        s_ack[3] = 0;

        // Contention: all four write S0, serviced 0,1,2,3.
        for (int i = 0; i < 4; i++) mset(i, 1, 1, 0, 32'h100 + i);
        s_ack[0] = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_ack", ackv(), 32'h1 << k);
            chk("cont_wdata", s_wdata[0], 32'h100 + k);
            tick;
            m_req[k] = 0;
        end
        // Pointer wrapped 3 -> 0, so M0 beats M2 and M3.
        mset(0, 1, 1, 0, 32'h200);
        mset(2, 1, 1, 0, 32'h202);
        mset(3, 1, 1, 0, 32'h203);
        #1;
        chk("wrap_ack", ackv(), 4'b0001);
        chk("wrap_wdata", s_wdata[0], 32'h200);
        tick;
        for (int i = 0; i < 4; i++) mset(i, 0, 0, 0, 0);
        s_ack[0] = 0;

        // Parallel: Mi -> S(3-i) in the same cycle.
        for (int i = 0; i < 4; i++) begin
            mset(i, 1, 1, (32'(3 - i) << 30) | 32'h10, 32'hA0 + i);
            s_ack[i] = 1;
        end
        #1;
        chk("par_ack", ackv(), 4'hF);
        for (int s = 0; s < 4; s++) chk("par_wdata", s_wdata[s], 32'hA0 + (3 - s));
        tick;
        for (int i = 0; i < 4; i++) begin
            mset(i, 0, 0, 0, 0);
            s_ack[i] = 0;
        end

        // Lock: M1 owns S2 for five un-acked cycles while M0 waits.
        mset(1, 1, 1, 32'h8000_0020, 32'h1111_1111);
        #1;
        chk("lk_m1_fwd", s_addr[2], 32'h8000_0020);
        tick;
        mset(0, 1, 1, 32'h8000_0040, 32'h2222_2222);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("lk_m0_stall", m_ack[0], 0);
            chk("lk_s2_wdata", s_wdata[2], 32'h1111_1111);
            chk("lk_s2_addr", s_addr[2], 32'h8000_0020);
            tick;
        end
        s_ack[2] = 1;
        #1;
        chk("lk_m1_ack", m_ack[1], 1);
        chk("lk_m0_noack", m_ack[0], 0);
        tick;
        m_req[1] = 0;
        #1;
        chk("lk_m0_grant", s_addr[2], 32'h8000_0040);
        chk("lk_m0_ack", m_ack[0], 1);
        tick;
        mset(0, 0, 0, 0, 0);
        s_ack[2] = 0;

        // Reset while S0 waits for M0's read response.
        mset(0, 1, 0, 32'h0000_0100, 0);
        s_ack[0] = 1;
        #1;
        chk("rr_m0_ack", m_ack[0], 1);
        tick;
        mset(0, 0, 0, 0, 0);
        s_ack[0] = 0;
        mset(1, 1, 1, 32'h4000_0000, 32'h3);
        mset(2, 1, 1, 0, 32'h302);
        #1;
        chk("rr_s1_req_pre", s_req[1], 1);
        chk("rr_s0_wait", s_req[0], 0);
        #2 rst_n = 0;
        s_ack[1]   = 1;
        s_resp[0]  = 1;
        s_rdata[0] = 32'hAAAA_AAAA;
        #1;
        chk("rr_s1_req", s_req[1], 0);
        chk("rr_s1_addr", s_addr[1], 0);
        chk("rr_m1_ack", m_ack[1], 0);
        chk("rr_m0_resp", m_resp[0], 0);
        chk("rr_m0_rdata", m_rdata[0], 0);
        chk("rr_s0_req", s_req[0], 0);
        #2 rst_n = 1;
        s_ack[1]   = 0;
        s_resp[0]  = 0;
        s_rdata[0] = 0;
        m_req[1]   = 0;
        mset(0, 1, 1, 0, 32'h300);
        mset(1, 1, 1, 0, 32'h301);
        mset(3, 1, 1, 0, 32'h303);
        s_ack[0] = 1;
        #1;
        chk("post_rst_ack", ackv(), 4'b0001);
        chk("post_rst_wdata", s_wdata[0], 32'h300);
        tick;
        for (int i = 0; i < 4; i++) mset(i, 0, 0, 0, 0);
        s_ack[0] = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cross_bar_4x4.md
Name: cross_bar_4x4

Overview:
- 4-master x 4-slave request/acknowledge bus crossbar; every master can reach every slave.
- Slave is selected by address bits [31:30].
- Per-slave round-robin arbitration; read responses are routed back to the issuing master.
- Sits between CPU/DMA-style masters and memory/peripheral slaves; all ports use the shared cross_bar_if bundle.

Parameters:
- N_MASTERS, 4, number of master ports (fixed by port list).
- N_SLAVES, 4, number of slave ports (fixed by port list).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- master_0_if..master_3_if  interface  -  crossbar acts as slave.
- slave_0_if..slave_3_if  interface  -  crossbar acts as master.
- cross_bar_if signals:
  - req 1 (master->slave)
  - addr 32 (m->s)
  - cmd 1, 0=read 1=write (m->s)
  - wdata 32 (m->s)
  - ack 1 (s->m)
  - resp 1 (s->m)
  - rdata 32 (s->m)

Behaviour:
- Reset: all master ack/resp/rdata = 0; all slave req/addr/cmd/wdata = 0; arbiter states IDLE; RR pointers = master 0; outstanding-read flags cleared. A reset mid-transaction abandons it silently.
- Target slave = addr[31:30]. addr is forwarded unmodified (full 32 bits).
- Master handshake:
  - Master holds req/addr/cmd/wdata stable until ack (1-cycle pulse).
  - Transfer completes in the cycle req&&ack.
  - Read data returns later as a 1-cycle resp pulse with rdata valid.
- Per-slave arbiter states: IDLE, LOCKED(owner), WAIT_RESP(owner).
- IDLE:
  - Eligible = masters with req=1, target=this slave, no outstanding read.
  - Grant the first eligible master at or after the RR pointer (circular).
  - Forward its req/addr/cmd/wdata to the slave combinationally (zero added latency).
  - slave ack is routed combinationally to the owner's ack.
  - ack in the same cycle: write -> stay IDLE; read -> WAIT_RESP(owner). Pointer = owner+1 mod 4.
  - No ack: -> LOCKED(owner).
- LOCKED: keep forwarding the owner until ack. Then apply the same write/read transitions and pointer update as IDLE. Other requesters stall.
- WAIT_RESP:
  - slave req=0.
  - slave resp/rdata are routed to the owner; master resp pulses the same cycle.
  - On resp -> IDLE.
- Non-granted masters see ack=0. A master's rdata = 0 when no resp is routed to it.
- Outstanding-read flag per master: set on read ack, cleared on resp. While set, the master is ineligible at all slaves, so a master never receives two resps in one cycle.
- Simultaneous events:
  - 4 masters to one slave: serviced 0,1,2,3 in order from reset.
  - Masters to distinct slaves: all proceed in parallel in the same cycle.
  - resp and new grant at the same slave in the same cycle: the new grant waits until the next cycle (IDLE entered first).
- Pointer wrap: 3 -> 0.

Optional Feature:
- Macro: CROSS_BAR_SVA_EN.
- Defined: SVA checkers compiled in:
  - grant one-hot per slave.
  - ack only routed to a requesting master.
  - addr/cmd/wdata stable while req&&!ack.
  - resp only in WAIT_RESP.
  - no master req while its read is outstanding; warns only.
- Undefined: no assertions; identical RTL behaviour.

Decomposition:
- Package cross_bar_pkg:
  - ADDR_W, DATA_W, N_MASTERS, N_SLAVES.
  - cmd_e (CMD_READ=0, CMD_WRITE=1).
  - arb_state_e (IDLE, LOCKED, WAIT_RESP).
  - master index typedef (2-bit).
- One sub-module cross_bar_arbiter: per-slave RR arbiter + state machine, instantiated 4x.
- Top does address decode, muxing and response routing.

Test Plan:
- Single write: M0 addr=0x4000_0010 cmd=1 wdata=0xDEADBEEF -> S1 sees req the same cycle with identical fields; S1 ack -> M0 ack the same cycle; other slaves req=0.
- Single read: M2 addr=0xC000_0004 read; S3 acks, resp 3 cycles later with rdata=0x1234_5678 -> M2 resp=1, rdata=0x1234_5678 in that cycle; S3 ignores new reqs until then.
- Contention: all 4 masters write to 0x0000_0000 from reset, S0 acks immediately -> grants in order M0,M1,M2,M3 on 4 consecutive cycles.
- Parallel: Mi -> slave (3-i) simultaneously -> all four acks the same cycle, no stalls.
- Lock: S2 delays ack 5 cycles while M1 owns it; M0 requests S2 meanwhile -> M0 stays un-acked; S2 fields remain M1's until ack.
- Reset mid-read: assert rst_n=0 during WAIT_RESP -> all outputs 0 asynchronously; after release, M0 is granted first.
